load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning the data-memory size in bytes: 1024 words.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_base  in  32  base register value
- req_offset  in  32  sign-extended immediate
- req_wdata  in  32  store data, low bits used for b/h
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access
- mem_base, mem_offset  out  32 each  address operands to the data memory
- mem_r_enabled, mem_w_enabled  out  1 each  memory strobes
- mem_w_data  out  32  word write data
- mem_r_data  in  32  memory read data, valid the cycle after mem_r_enabled

Function
REQ-004 SHALL accept a request when req_valid && req_ready; req_ready=1 only in IDLE.
REQ-005 SHALL latch base, offset, op, we and wdata on accept.
REQ-006 SHALL compute addr = base + offset, mod 2^32.
REQ-007 SHALL drive mem_base and mem_offset from the latched values.
REQ-008 SHALL flag an error for h/hu with addr[0]=1, w with addr[1:0]!=0, or addr >= MEM_BYTES. On error: no memory strobe, resp_err=1, resp_data=0.
REQ-009 SHALL implement states IDLE, RD, WAIT, WR, RESP.
REQ-010 SHALL make these transitions:
- IDLE->RESP on error.
- IDLE->WR on sw.
- IDLE->RD on any load, sb or sh.
- RD->WAIT.
- WAIT->RESP on loads.
- WAIT->WR on sb/sh.
- WR->RESP.
- RESP->IDLE.
REQ-011 SHALL assert mem_r_enabled only in RD and mem_w_enabled only in WR, never both at once.
REQ-012 SHALL use little-endian byte lanes: byte k = bits [8k+7:8k], k = addr[1:0]; halfword at addr[1]*16.
REQ-013 SHALL capture the load result in WAIT: selected lane, sign-extended for b/h/w, zero-extended for bu/hu.
REQ-014 SHALL perform sb/sh as read-modify-write: merge req_wdata low byte/half into the lane of the WAIT-cycle word; other lanes unchanged.
REQ-015 SHALL drive mem_w_data with the full word in WR for sw.
REQ-016 SHALL meet this latency, with accept at cycle 0 and resp_valid at cycle N:
- error N=1
- sw N=2
- loads N=3
- sb/sh N=4
REQ-017 SHALL assert resp_valid for exactly one cycle in RESP. There is no response backpressure.
REQ-018 SHALL hold resp_data/resp_err stable until the next RESP.
REQ-019 SHALL treat req_op values 011/110/111 as errors.

Reset
REQ-020 SHALL, on rst, go to IDLE with req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_r_enabled=0, mem_w_enabled=0, mem_w_data=0, mem_base=0, mem_offset=0.
REQ-021 SHALL, when rst is asserted mid-operation, abandon the operation: no later write strobe, no response.

Structure
REQ-022 SHALL place the op encodings, the state enum and MEM_BYTES default in shared package lsu_pkg.
REQ-023 SHALL use one combinational sub-module, lsu_align (load lane extract/extend and store lane merge), instantiated once.

Verification
REQ-024 SHALL preload memory word 1 = 0x8899AABB, then lb base=4 offset=1 -> resp_data=0xFFFFFFAA at cycle 3, resp_err=0.
REQ-025 SHALL check lbu and lhu against the same word: lbu base=4 offset=1 -> 0x000000AA; lhu base=4 offset=2 -> 0x00008899.
REQ-026 SHALL check sb base=8 offset=0xFFFFFFFE wdata=0x12345611 -> mem_w_enabled in cycle 3 with word 0x8811AABB, resp_valid cycle 4, resp_data=0.
REQ-027 SHALL check sw base=0 offset=0 wdata=0xDEADBEEF -> mem_r_enabled never high, write in cycle 1, resp cycle 2; a following lw addr 0 returns 0xDEADBEEF.
REQ-028 SHALL check errors: lw addr 6, lh addr 3 and lw addr 0x1000 -> resp_err=1, resp_data=0, no strobes, resp cycle 1.
REQ-029 SHALL check rst during WAIT of an sb -> IDLE next cycle, req_ready=1, no mem_w_enabled, no resp_valid, memory word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// default memory size and the access-error rule.
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 32'd4096;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Unsigned variants only exist for loads; reserved encodings are always errors.
  function automatic logic access_err(input op_e op, input logic we,
                                      input logic [31:0] addr, input logic [31:0] mem_bytes);
    logic bad;
    case (op)
      OP_B:    bad = 1'b0;
      OP_H:    bad = addr[0];
      OP_W:    bad = (addr[1:0] != 2'b00);
      OP_BU:   bad = we;
      OP_HU:   bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    return bad | (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_base;
  logic [31:0] mem_offset;
  logic        mem_r_enabled;
  logic        mem_w_enabled;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  modport slave (
    input  req_valid, req_we, req_op, req_base, req_offset, req_wdata, mem_r_data,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_base, mem_offset, mem_r_enabled, mem_w_enabled, mem_w_data
  );

  modport master (
    output req_valid, req_we, req_op, req_base, req_offset, req_wdata, mem_r_data,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_base, mem_offset, mem_r_enabled, mem_w_enabled, mem_w_data
  );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsh  = {i_addr_lo, 3'b000};
  assign w_hsh  = {i_addr_lo[1], 4'b0000};
  assign w_byte = 8'(i_rdata >> w_bsh);
  assign w_half = 16'(i_rdata >> w_hsh);

  // Lane select for loads and lane replacement for sb/sh.
  always_comb begin
    o_load_data  = 32'd0;
    o_merge_data = i_rdata;
    case (i_op)
      OP_B: begin
        o_load_data  = {{24{w_byte[7]}}, w_byte};
        o_merge_data = (i_rdata & ~(32'h0000_00FF << w_bsh)) | ({24'd0, i_wdata[7:0]} << w_bsh);
      end
      OP_H: begin
        o_load_data  = {{16{w_half[15]}}, w_half};
        o_merge_data = (i_rdata & ~(32'h0000_FFFF << w_hsh)) | ({16'd0, i_wdata} << w_hsh);
      end
      OP_W:    o_load_data = i_rdata;
      OP_BU:   o_load_data = {24'd0, w_byte};
      OP_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
)
(
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  state_e      r_state;
  state_e      w_next_state;
  logic        r_we;
  op_e         r_op;
  logic [31:0] r_base;
  logic [31:0] r_offset;
  logic [15:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_data;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic [31:0] r_mem_w_data;

  logic [31:0] w_req_addr;
  logic [1:0]  w_lat_lo;
  logic        w_req_err;
  logic        w_accept;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_req_addr = bus.req_base + bus.req_offset;
  assign w_lat_lo   = r_base[1:0] + r_offset[1:0];
  assign w_accept   = bus.req_valid && r_req_ready;
  assign w_req_err  = access_err(op_e'(bus.req_op), bus.req_we, w_req_addr, MEM_BYTES);

  lsu_align u_align (
    .i_op         (r_op),
    .i_addr_lo    (w_lat_lo),
    .i_rdata      (bus.mem_r_data),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_accept)                                w_next_state = ST_IDLE;
        else if (w_req_err)                           w_next_state = ST_RESP;
        else if (bus.req_we && (bus.req_op == OP_W))  w_next_state = ST_WR;
        else                                          w_next_state = ST_RD;
      end
      ST_RD:   w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (r_we) w_next_state = ST_WR;
        else      w_next_state = ST_RESP;
      end
      ST_WR:   w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, latched request and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_op         <= OP_B;
      r_base       <= 32'd0;
      r_offset     <= 32'd0;
      r_wdata      <= 16'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= 32'd0;
      r_mem_r_en   <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_mem_w_data <= 32'd0;
    end else begin
      r_state      <= w_next_state;
      r_req_ready  <= (w_next_state == ST_IDLE);
      r_resp_valid <= (w_next_state == ST_RESP);
      r_mem_r_en   <= (w_next_state == ST_RD);
      r_mem_w_en   <= (w_next_state == ST_WR);
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_op     <= op_e'(bus.req_op);
        r_base   <= bus.req_base;
        r_offset <= bus.req_offset;
        r_wdata  <= bus.req_wdata[15:0];
      end
      // sw writes straight from the request; sb/sh write the merged WAIT word.
      if (w_next_state == ST_WR) begin
        r_mem_w_data <= (r_state == ST_IDLE) ? bus.req_wdata : w_merge_data;
      end
      if (w_next_state == ST_RESP) begin
        r_resp_err  <= (r_state == ST_IDLE);
        r_resp_data <= (r_state == ST_WAIT) ? w_load_data : 32'd0;
      end
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_err      = r_resp_err;
  assign bus.resp_data     = r_resp_data;
  assign bus.mem_base      = r_base;
  assign bus.mem_offset    = r_offset;
  assign bus.mem_r_enabled = r_mem_r_en;
  assign bus.mem_w_enabled = r_mem_w_en;
  assign bus.mem_w_data    = r_mem_w_data;

endmodule
